// File: rtl/trng_key_arbiter.sv
// trng_key_arbiter: round-robin sharing of one TRNG key source among N_REQ requesters,
// with valid/ack key handover, ack_read release pulse and per-requester error mapping.
module trng_key_arbiter #(
    parameter int N_REQ      = 4,
    parameter int N_BITS_KEY = 32,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [N_REQ-1:0]      ack_i,
    output logic [N_REQ-1:0]      gnt_o,
    output logic [N_REQ-1:0]      valid_o,
    output logic [N_BITS_KEY-1:0] key_o,
    output logic [N_REQ-1:0]      err_o,
    output logic                  busy_o,
    output logic                  trng_en_o,
    output logic                  trng_ack_read_o,
    input  logic [N_BITS_KEY-1:0] trng_key_i,
    input  logic                  trng_ready_i,
    input  logic                  trng_intr_i
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_KEY, DELIVER, RELEASE, ERROR} state_t;

    state_t                state, nxt;
    logic [IW-1:0]         ptr, idx, pick, inc_idx, nxt_idx, nxt_ptr;
    logic [CW-1:0]         cnt, nxt_cnt;
    logic [N_BITS_KEY-1:0] key_q, nxt_key;
    logic [N_REQ-1:0]      gnt_q, valid_q, err_q, oh;
    logic                  en_q, ack_read_q, timeout;

    // descending scan so the lowest offset from ptr wins
    always_comb begin
        pick = ptr;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req_i[IW'((int'(ptr) + i) % N_REQ)]) pick = IW'((int'(ptr) + i) % N_REQ);
    end

    assign inc_idx = (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
    assign timeout = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        nxt     = state;
        nxt_idx = idx;
        nxt_ptr = ptr;
        nxt_key = key_q;
        case (state)
            IDLE: if (|req_i) begin
                nxt     = WAIT_KEY;
                nxt_idx = pick;
            end
            WAIT_KEY: begin
                if (trng_intr_i) nxt = ERROR;
                else if (!req_i[idx]) nxt = IDLE;
                else if (trng_ready_i) begin
                    nxt     = DELIVER;
                    nxt_key = trng_key_i;
                end else if (timeout) nxt = ERROR;
            end
            DELIVER: begin
                if (trng_intr_i) nxt = ERROR;
                else if (ack_i[idx] || !req_i[idx]) nxt = RELEASE;
            end
            RELEASE: begin
                nxt     = IDLE;
                nxt_ptr = inc_idx;
            end
            ERROR: if (req_i == '0) begin
                nxt     = IDLE;
                nxt_ptr = inc_idx;
            end
            default: nxt = IDLE;
        endcase
        if (nxt != DELIVER) nxt_key = '0;
        nxt_cnt = (state == WAIT_KEY && nxt == WAIT_KEY) ? (&cnt ? cnt : cnt + 1'b1) : '0;
        oh      = N_REQ'(1) << nxt_idx;
    end

    // outputs are registered from the next state so they line up with it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            idx        <= '0;
            ptr        <= '0;
            cnt        <= '0;
            key_q      <= '0;
            gnt_q      <= '0;
            valid_q    <= '0;
            err_q      <= '0;
            en_q       <= 1'b0;
            ack_read_q <= 1'b0;
        end else begin
            state      <= nxt;
            idx        <= nxt_idx;
            ptr        <= nxt_ptr;
            cnt        <= nxt_cnt;
            key_q      <= nxt_key;
            gnt_q      <= (nxt == WAIT_KEY || nxt == DELIVER || nxt == RELEASE) ? oh : '0;
            valid_q    <= (nxt == DELIVER) ? oh : '0;
            err_q      <= (nxt == ERROR && state != ERROR) ? oh : '0;
            en_q       <= nxt == WAIT_KEY || nxt == DELIVER;
            ack_read_q <= nxt == RELEASE;
        end
    end

    assign gnt_o           = gnt_q;
    assign valid_o         = valid_q;
    assign err_o           = err_q;
    assign key_o           = |valid_q ? key_q : '0;
    assign busy_o          = state != IDLE;
    assign trng_en_o       = en_q;
    assign trng_ack_read_o = ack_read_q;
endmodule

// File: tb/tb_trng_key_arbiter.sv
// tb_trng_key_arbiter: scoreboard bench for trng_key_arbiter with a scripted TRNG model;
// three instances share stimulus to cover TIMEOUT=4096, 16 and 0.
module tb_trng_key_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  req = '0, ack = '0;
    logic [31:0] trng_key = '0;
    logic        trng_ready = 1'b0, trng_intr = 1'b0;

    logic [3:0]  gnt, valid, err, gnt_t, valid_t, err_t, gnt_z, valid_z, err_z;
    logic [31:0] key_o, key_t, key_z;
    logic        busy, en, ack_read, busy_t, en_t, ack_read_t, busy_z, en_z, ack_read_z;

    trng_key_arbiter #(.N_REQ(4), .N_BITS_KEY(32), .TIMEOUT(4096)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ack_i(ack), .gnt_o(gnt), .valid_o(valid),
        .key_o(key_o), .err_o(err), .busy_o(busy), .trng_en_o(en), .trng_ack_read_o(ack_read),
        .trng_key_i(trng_key), .trng_ready_i(trng_ready), .trng_intr_i(trng_intr));
    trng_key_arbiter #(.N_REQ(4), .N_BITS_KEY(32), .TIMEOUT(16)) dut_t (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ack_i(ack), .gnt_o(gnt_t), .valid_o(valid_t),
        .key_o(key_t), .err_o(err_t), .busy_o(busy_t), .trng_en_o(en_t), .trng_ack_read_o(ack_read_t),
        .trng_key_i(trng_key), .trng_ready_i(trng_ready), .trng_intr_i(trng_intr));
    trng_key_arbiter #(.N_REQ(4), .N_BITS_KEY(32), .TIMEOUT(0)) dut_z (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ack_i(ack), .gnt_o(gnt_z), .valid_o(valid_z),
        .key_o(key_z), .err_o(err_z), .busy_o(busy_z), .trng_en_o(en_z), .trng_ack_read_o(ack_read_z),
        .trng_key_i(trng_key), .trng_ready_i(trng_ready), .trng_intr_i(trng_intr));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int err0_cnt = 0, errz_cnt = 0, valid_cnt = 0, ack_read_cnt = 0;
    logic [35:0] sb[$];

    always @(negedge clk) begin
        err0_cnt     <= err0_cnt + int'(|err);
        errz_cnt     <= errz_cnt + int'(|err_z);
        valid_cnt    <= valid_cnt + int'(|valid);
        ack_read_cnt <= ack_read_cnt + int'(ack_read);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; ack = '0; trng_ready = 1'b0; trng_intr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_key"}, key_o, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_en"}, en, 0);
        chk({tag, "_ackrd"}, ack_read, 0);
    endtask

    task automatic expect_key();
        logic [35:0] e;
        int n = 0;
        while (valid == 0 && n < 5) begin step(); n++; end
        chk("valid_wait", n < 5, 1);
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
            e = sb.pop_front();
            chk("valid", valid, e[35:32]);
            chk("key", key_o, e[31:0]);
        end
    endtask

    task automatic give_key(input logic [3:0] owner, input logic [31:0] k);
        trng_ready = 1'b1; trng_key = k;
        sb.push_back({owner, k});
        step();
        trng_ready = 1'b0; trng_key = '0;
    endtask

    // full handover: expects the grant one cycle after the current point
    task automatic serve(input logic [3:0] exp_gnt, input logic [31:0] k, input int delay);
        int n = 0;
        while (gnt == 0 && n < 20) begin step(); n++; end
        chk("gnt_latency", n, 1);
        chk("gnt", gnt, exp_gnt);
        chk("en", en, 1);
        chk("valid_early", valid, 0);
        repeat (delay) step();
        give_key(exp_gnt, k);
        expect_key();
        chk("ackrd_early", ack_read, 0);
        ack = exp_gnt;
        step();
        ack = '0;
        chk("ackrd", ack_read, 1);
        chk("rel_gnt", gnt, exp_gnt);
        chk("rel_valid", valid, 0);
        chk("rel_key", key_o, 0);
        step();
        chk("ackrd_pulse", ack_read, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int n, s_ack, s_valid, s_err0, s_errz;

        // 1: single request, slow TRNG
        do_reset();
        check_idle("rst");
        req = 4'b0001;
        serve(4'b0001, 32'hDEADBEEF, 49);
        req = '0;
        step();
        check_idle("t1_end");

        // 2: all requesting, round robin order
        do_reset();
        req = 4'b1111;
        serve(4'b0001, 32'h11111111, 2);
        serve(4'b0010, 32'h22222222, 0);
        serve(4'b0100, 32'h33333333, 5);
        serve(4'b1000, 32'h44444444, 1);
        serve(4'b0001, 32'h55555555, 0);
        req = '0;

        // 3: health failure while waiting
        do_reset();
        req = 4'b0010;
        step();
        chk("t3_gnt", gnt, 4'b0010);
        trng_intr = 1'b1;
        step();
        trng_intr = 1'b0;
        chk("t3_err", err, 4'b0010);
        chk("t3_en", en, 0);
        chk("t3_gnt0", gnt, 0);
        chk("t3_busy", busy, 1);
        step();
        chk("t3_err_pulse", err, 0);
        step();
        chk("t3_hold", busy, 1);
        req = '0;
        step();
        chk("t3_exit", busy, 0);
        req = 4'b1111;
        serve(4'b0100, 32'hA5A5A5A5, 3);
        req = '0;

        // 4: timeout 16 vs disabled
        do_reset();
        s_errz = errz_cnt; s_err0 = err0_cnt;
        req = 4'b0001;
        step();
        n = 0;
        while (err_t == 0 && n < 40) begin
            if (en_t) n++;
            step();
        end
        chk("t4_cycles", n, 16);
        chk("t4_err", err_t, 4'b0001);
        chk("t4_en", en_t, 0);
        chk("t4_z_en", en_z, 1);
        step();
        chk("t4_err_pulse", err_t, 0);
        repeat (60) step();
        chk("t4_z_noerr", errz_cnt - s_errz, 0);
        chk("t4_0_noerr", err0_cnt - s_err0, 0);
        chk("t4_z_busy", busy_z, 1);
        req = '0;

        // 5: owner drops request in WAIT_KEY and in DELIVER
        do_reset();
        s_ack = ack_read_cnt;
        req = 4'b0001;
        step();
        step();
        step();
        req = '0;
        step();
        chk("t5_wdrop_busy", busy, 0);
        chk("t5_wdrop_gnt", gnt, 0);
        step();
        chk("t5_no_ackrd", ack_read_cnt - s_ack, 0);
        req = 4'b1111;
        step();
        chk("t5_ptr_kept", gnt, 4'b0001);
        give_key(4'b0001, 32'hCAFEF00D);
        expect_key();
        req = '0;
        step();
        chk("t5_ddrop_ackrd", ack_read, 1);
        chk("t5_ddrop_key", key_o, 0);
        chk("t5_ddrop_valid", valid, 0);
        step();
        chk("t5_ddrop_idle", busy, 0);

        // 6: ready and intr together, then async reset during DELIVER
        do_reset();
        s_valid = valid_cnt;
        req = 4'b0100;
        step();
        chk("t6_gnt", gnt, 4'b0100);
        trng_ready = 1'b1; trng_intr = 1'b1; trng_key = 32'h0BADF00D;
        step();
        trng_ready = 1'b0; trng_intr = 1'b0;
        chk("t6_err", err, 4'b0100);
        chk("t6_key", key_o, 0);
        req = '0;
        step();
        step();
        chk("t6_novalid", valid_cnt - s_valid, 0);
        req = 4'b0001;
        step();
        give_key(4'b0001, 32'h12345678);
        expect_key();
        s_ack = ack_read_cnt;
        rst_n = 1'b0;
        #1;
        check_idle("t6_async");
        step();
        rst_n = 1'b1;
        req = '0;
        step();
        chk("t6_no_ackrd", ack_read_cnt - s_ack, 0);
        chk("t6_sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
